// File: rtl/fabric_config_loader.sv
// Bitstream loader: parses a header plus (addr, data) pairs and replays
// each pair onto the shared tile config bus for exactly one cycle.
module fabric_config_loader #(
  parameter logic [15:0] MAGIC     = 16'hC0F1,
  parameter logic [15:0] MAX_PAIRS = 16'd1024,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        bs_valid,
  input  logic [31:0] bs_data,
  output logic        bs_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] pairs_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_remaining;
  logic [15:0] r_addr_sec;
  logic [15:0] r_addr_tile;
  logic [31:0] r_cfg_addr;
  logic [31:0] r_cfg_data;
  logic        r_bus_vld;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_pairs;

  logic        w_xfer;
  logic        w_hdr_bad;
  logic        w_sec_bad;
  logic        w_cnt_zero;
  logic        w_last;
  logic        w_start;
  logic        w_load_hdr;
  logic        w_load_addr;
  logic        w_wr;
  logic        w_set_done;
  logic        w_set_err;
  logic        w_ready;

  assign w_xfer     = bs_valid && w_ready;
  assign w_hdr_bad  = (bs_data[31:16] != MAGIC) ||
                      (bs_data[15:0] > MAX_PAIRS);
  assign w_sec_bad  = (bs_data[31:16] < 16'd4) ||
                      (bs_data[31:16] > 16'd7);
  assign w_cnt_zero = (bs_data[15:0] == 16'd0);
  assign w_last     = (r_remaining == 16'd1);

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_start     = 1'b0;
    w_load_hdr  = 1'b0;
    w_load_addr = 1'b0;
    w_wr        = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_start = 1'b1;
          w_next  = S_HDR;
        end
      end
      S_HDR: begin
        w_ready = 1'b1;
        if (bs_valid) begin
          if (w_hdr_bad) begin
            w_set_err = 1'b1;
            w_next    = S_ERR;
          end else if (w_cnt_zero) begin
            w_set_done = 1'b1;
            w_next     = S_DONE;
          end else begin
            w_load_hdr = 1'b1;
            w_next     = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        w_ready = 1'b1;
        if (bs_valid) begin
          if (w_sec_bad) begin
            w_set_err = 1'b1;
            w_next    = S_ERR;
          end else begin
            w_load_addr = 1'b1;
            w_next      = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (bs_valid) begin
          w_wr = 1'b1;
          if (w_last) begin
            w_set_done = 1'b1;
            w_next     = S_DONE;
          end else begin
            w_next = S_ADDR;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 16'd0;
      r_addr_sec  <= 16'd0;
      r_addr_tile <= 16'd0;
      r_cfg_addr  <= IDLE_ADDR;
      r_cfg_data  <= 32'd0;
      r_bus_vld   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_pairs     <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_bus_vld  <= w_wr;
      r_cfg_addr <= IDLE_ADDR;
      r_cfg_data <= 32'd0;
      if (w_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
        r_pairs <= 16'd0;
      end
      if (w_load_hdr) r_remaining <= bs_data[15:0];
      if (w_load_addr) begin
        r_addr_sec  <= bs_data[31:16];
        r_addr_tile <= bs_data[15:0];
      end
      // bus carries the pair for one cycle, then falls back to idle
      if (w_wr) begin
        r_cfg_addr  <= {r_addr_sec, r_addr_tile};
        r_cfg_data  <= bs_data;
        r_remaining <= r_remaining - 16'd1;
        r_pairs     <= r_pairs + 16'd1;
      end
      if (w_set_done) r_done  <= 1'b1;
      if (w_set_err)  r_error <= 1'b1;
    end
  end

  assign bs_ready      = w_ready;
  assign config_addr   = r_cfg_addr;
  assign config_data   = r_cfg_data;
  assign busy          = w_ready || r_bus_vld;
  assign done          = r_done;
  assign error         = r_error;
  assign pairs_written = r_pairs;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Randomized bench for fabric_config_loader against a stream-level
// parsing model of the bitstream format.
module tb_fabric_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        bs_valid;
  logic [31:0] bs_data;
  logic        bs_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] pairs_written;

  always #5 clk = ~clk;

  fabric_config_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bs_valid     (bs_valid),
    .bs_data      (bs_data),
    .bs_ready     (bs_ready),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .pairs_written(pairs_written)
  );

  int          ncmp = 0;
  int          nerr = 0;
  logic [31:0] stream[$];
  logic [63:0] obs_wr[$];
  logic [1:0]  obs_flag[$];
  logic [63:0] exp_wr[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_cons;
  int          consumed;

  // every non-idle bus cycle is one observed write
  always @(negedge clk) begin
    if (config_addr !== 32'h0 || config_data !== 32'h0) begin
      obs_wr.push_back({config_addr, config_data});
      obs_flag.push_back({busy, done});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Walk the word list the way the format is defined.
  task automatic model();
    logic [31:0] h;
    logic [31:0] a;
    int          cnt;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_cons = 1;
    h   = stream[0];
    cnt = int'(h[15:0]);
    if (h[31:16] != 16'hC0F1 || cnt > 1024) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      a = stream[1 + 2 * i];
      exp_cons++;
      if (a[31:16] < 16'd4 || a[31:16] > 16'd7) begin
        exp_err = 1'b1;
        return;
      end
      exp_wr.push_back({a, stream[2 + 2 * i]});
      exp_cons++;
    end
    exp_done = 1'b1;
  endtask

  // fault: 0 none, 1 bad magic, 2 bad section, 3 count too big
  task automatic gen(input int cnt, input int fault);
    int          bad;
    logic [15:0] sec;
    stream.delete();
    bad = (fault == 2) ? int'($urandom_range(cnt - 1)) : -1;
    if (fault == 1)
      stream.push_back({16'hBEEF, 16'(cnt)});
    else if (fault == 3)
      stream.push_back({16'hC0F1, 16'd1025 + 16'($urandom_range(200))});
    else
      stream.push_back({16'hC0F1, 16'(cnt)});
    for (int i = 0; i < cnt; i++) begin
      if (i == bad)
        sec = $urandom_range(1) ? 16'($urandom_range(3))
                                : 16'($urandom_range(16'hFFFF, 8));
      else
        sec = 16'(4 + $urandom_range(3));
      stream.push_back({sec, 16'($urandom)});
      stream.push_back($urandom);
    end
  endtask

  task automatic begin_load();
    obs_wr.delete();
    obs_flag.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", 64'(bs_ready), 64'd1);
    chk("start_clr", {done, error, pairs_written}, 64'd0);
  endtask

  task automatic feed(input int gap, input int start_at, input int limit);
    int   idx;
    int   cyc;
    logic x;
    idx = 0;
    cyc = 0;
    while (1) begin
      if (idx < stream.size()) begin
        bs_data  = stream[idx];
        bs_valid = ($urandom_range(99) >= gap);
      end else begin
        bs_valid = 1'b0;
      end
      start = (cyc == start_at);
      x     = bs_valid && bs_ready;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (x) idx++;
      if (!bs_ready || idx >= stream.size()) break;
      if (cyc >= limit) begin
        ncmp++;
        nerr++;
        $error("FAIL feed_timeout: observed %0d cycles expected < %0d",
               cyc, limit);
        break;
      end
    end
    bs_valid = 1'b0;
    consumed = idx;
  endtask

  task automatic finish_load(input string tag);
    int n;
    model();
    chk({tag, "_cons"}, 64'(consumed), 64'(exp_cons));
    chk({tag, "_flags"}, {busy, done, error},
        {exp_done && exp_wr.size() > 0, exp_done, exp_err});
    chk({tag, "_pairs"}, 64'(pairs_written), 64'(exp_wr.size()));
    bs_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_idle"}, {bs_ready, busy, config_addr}, 64'd0);
    end
    bs_valid = 1'b0;
    chk({tag, "_sticky"}, {done, error}, {exp_done, exp_err});
    chk({tag, "_nwr"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wr"}, obs_wr[i], exp_wr[i]);
      chk({tag, "_wrflag"}, 64'(obs_flag[i]),
          {1'b1, i == exp_wr.size() - 1 && exp_done});
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bs_valid = 1'b0;
    bs_data  = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", {bs_ready, busy, done, error, pairs_written}, 64'd0);
    chk("rst_bus", {config_addr, config_data}, 64'd0);

    stream = '{32'hC0F1_0002, 32'h0007_0003, 32'h0000_00AA,
               32'h0004_0001, 32'h0000_0002};
    begin_load();
    feed(0, -1, 200);
    finish_load("t1");
    chk("t1_w0", obs_wr.size() > 0 ? obs_wr[0] : 64'h0,
        64'h0007_0003_0000_00AA);
    chk("t1_w1", obs_wr.size() > 1 ? obs_wr[1] : 64'h0,
        64'h0004_0001_0000_0002);

    stream = '{32'hC0F1_0000, 32'h0004_0001};
    begin_load();
    feed(0, -1, 200);
    finish_load("t2");

    stream = '{32'hBEEF_0001, 32'h0004_0001, 32'h0000_0005};
    begin_load();
    feed(0, -1, 200);
    finish_load("t3");

    stream = '{32'hC0F1_0002, 32'h0004_0010, 32'h0000_0011,
               32'h0003_0005, 32'h0000_0022};
    begin_load();
    feed(0, -1, 200);
    finish_load("t4");

    stream = '{32'hC0F1_0401, 32'h0004_0001, 32'h0000_0001};
    begin_load();
    feed(0, -1, 200);
    finish_load("cnt_over");

    gen(3, 0);
    begin_load();
    feed(40, 3, 500);
    finish_load("t5");

    for (int k = 0; k < 10; k++) begin
      gen(1 + $urandom_range(5), (k % 3 == 0) ? 0 : $urandom_range(3));
      begin_load();
      feed($urandom_range(60), -1, 1000);
      finish_load("rnd");
    end

    gen(1024, 0);
    begin_load();
    feed(0, -1, 10000);
    finish_load("cnt_max");

    gen(3, 0);
    begin
      logic [31:0] d2;
      d2 = stream[4];
      stream = stream[0:3];
      begin_load();
      feed(0, -1, 200);
      bs_data  = d2;
      bs_valid = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      bs_valid = 1'b0;
      chk("t6_outs", {bs_ready, busy, done, error, pairs_written}, 64'd0);
      chk("t6_bus", {config_addr, config_data}, 64'd0);
      repeat (3) @(negedge clk);
      chk("t6_nwr", 64'(obs_wr.size()), 64'd1);
      chk("t6_idle", {bs_ready, busy, config_addr}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
